// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
// The state enum lives here so the top and any future siblings agree on encoding.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int DEF_RST_PULSE_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES         = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear on the synchronous active-low reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses the PLL reset, waits for a stable lock, releases
// downstream reset, retries on failure and latches a fault after too many attempts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       clear_fault,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_cnt
);

  // The shared counter only ever reaches (largest parameter - 1) before being cleared.
  localparam int CNT_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  logic lock_s;

  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             fail;
  logic             pll_rst_q, sys_rst_n_q, ready_q, fault_q;

  sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    fail    = 1'b0;

    unique case (state_q)
      PLLRST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        // Lock is checked first so a lock arriving on the timeout cycle still wins.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt_q == STB_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          state_d = PLLRST;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        if (clear_fault) begin
          retry_d = '0;
          state_d = PLLRST;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PLLRST;
        cnt_d   = '0;
      end
    endcase

    if (fail) begin
      retry_d = retry_q + 4'd1;
      cnt_d   = '0;
      state_d = (retry_d == RETRY_LIMIT) ? FAULT : PLLRST;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= PLLRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_rst_q   <= (state_d == PLLRST) || (state_d == FAULT);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_count   = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters (4/20/8/3).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 3;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       clear_fault = 1'b0;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .LOCK_STABLE_CYCLES  (ST),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .clear_fault   (clear_fault),
    .pll_rst       (pll_rst),
    .sys_rst_n     (sys_rst_n),
    .ready         (ready),
    .fault         (fault),
    .retry_count   (retry_count),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1ms", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench at the sample just after the last reset edge (PLLRST, counter 0).
  task automatic do_reset();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    clear_fault = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic count_pll_rst(input logic lvl, output int n);
    n = 0;
    while (pll_rst === lvl && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_ready(input logic lvl, output int n);
    n = 0;
    while (ready !== lvl && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: got rst=%b srn=%b rdy=%b flt=%b retry=%0d loss=%0d required 1 0 0 0 0 0",
               pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_cnt);
    end
  endtask

  task automatic test_lock_sequence();
    int n;
    do_reset();
    count_pll_rst(1'b1, n);
    checks++;
    if (n !== RP) begin
      errors++;
      $display("FAIL lock_seq_pulse: got %0d cycles required %0d", n, RP);
    end
    repeat (4) tick();
    pll_locked = 1'b1;
    tick();                      // first edge that samples locked=1
    wait_ready(1'b1, n);         // 2 sync + 8 stable edges after that edge
    checks++;
    if (n !== 2 + ST) begin
      errors++;
      $display("FAIL lock_seq_ready_latency: got %0d required %0d", n, 2 + ST);
    end
    checks++;
    if ({sys_rst_n, pll_rst, fault, retry_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL lock_seq_run_outputs: got srn=%b rst=%b flt=%b retry=%0d required 1 0 0 0",
               sys_rst_n, pll_rst, fault, retry_count);
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    do_reset();
    for (int i = 0; i < MR; i++) begin
      count_pll_rst(1'b1, n);
      checks++;
      if (n !== RP) begin
        errors++;
        $display("FAIL timeout_pulse%0d: got %0d required %0d", i, n, RP);
      end
      count_pll_rst(1'b0, n);
      checks++;
      if (n !== TO) begin
        errors++;
        $display("FAIL timeout_wait%0d: got %0d required %0d", i, n, TO);
      end
      checks++;
      if (retry_count !== 4'(i + 1)) begin
        errors++;
        $display("FAIL timeout_retry%0d: got %0d required %0d", i, retry_count, i + 1);
      end
    end
    checks++;
    if ({fault, pll_rst, sys_rst_n, ready} !== 4'b1100) begin
      errors++;
      $display("FAIL fault_entry: got flt=%b rst=%b srn=%b rdy=%b required 1 1 0 0",
               fault, pll_rst, sys_rst_n, ready);
    end
    repeat (5) tick();
    checks++;
    if ({fault, pll_rst, retry_count} !== {1'b1, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL fault_hold: got flt=%b rst=%b retry=%0d required 1 1 3",
               fault, pll_rst, retry_count);
    end
  endtask

  task automatic test_clear_fault();
    int n;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    checks++;
    if ({fault, pll_rst, retry_count} !== {1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL clear_fault_exit: got flt=%b rst=%b retry=%0d required 0 1 0",
               fault, pll_rst, retry_count);
    end
    count_pll_rst(1'b1, n);
    checks++;
    if (n !== RP) begin
      errors++;
      $display("FAIL clear_fault_pulse: got %0d required %0d", n, RP);
    end
    pll_locked = 1'b1;
    wait_ready(1'b1, n);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    tick();
    tick();
    checks++;
    if ({ready, fault, pll_rst, retry_count} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL clear_fault_in_run: got rdy=%b flt=%b rst=%b retry=%0d required 1 0 0 0",
               ready, fault, pll_rst, retry_count);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL loss_early: ready got %b required 1 two cycles after drop", ready);
    end
    tick();
    checks++;
    if ({sys_rst_n, ready, pll_rst, lock_loss_cnt} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL loss_response: got srn=%b rdy=%b rst=%b loss=%0d required 0 0 1 1",
               sys_rst_n, ready, pll_rst, lock_loss_cnt);
    end
    count_pll_rst(1'b1, n);
    checks++;
    if (n !== RP) begin
      errors++;
      $display("FAIL loss_pulse: got %0d required %0d", n, RP);
    end
    wait_ready(1'b1, n);         // lock_s already high: 1 edge to STABLE + 8 stable
    checks++;
    if (n !== 1 + ST || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL loss_relock: got %0d cycles retry=%0d required %0d cycles retry=0",
               n, retry_count, 1 + ST);
    end
  endtask

  task automatic test_stable_glitch();
    int n;
    do_reset();
    count_pll_rst(1'b1, n);
    pll_locked = 1'b1;
    repeat (4) tick();           // now in STABLE
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    checks++;
    if (pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL glitch_early: pll_rst got %b required 0", pll_rst);
    end
    tick();
    checks++;
    if ({pll_rst, retry_count, ready, fault} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL glitch_retry: got rst=%b retry=%0d rdy=%b flt=%b required 1 1 0 0",
               pll_rst, retry_count, ready, fault);
    end
  endtask

  task automatic test_loss_saturation();
    int n;
    int timeouts;
    logic [7:0] loss_at_255;
    timeouts = 0;
    loss_at_255 = '0;
    for (int i = 0; i < 256; i++) begin
      wait_ready(1'b1, n);
      if (n >= 200) timeouts++;
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      wait_ready(1'b0, n);
      if (n >= 200) timeouts++;
      if (i == 254) loss_at_255 = lock_loss_cnt;
    end
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("FAIL sat_timeouts: got %0d bounded waits expired required 0", timeouts);
    end
    checks++;
    if (loss_at_255 !== 8'd255) begin
      errors++;
      $display("FAIL sat_255th: got %0d required 255", loss_at_255);
    end
    checks++;
    if (lock_loss_cnt !== 8'd255 || retry_count !== 4'd1) begin
      errors++;
      $display("FAIL sat_256th: got loss=%0d retry=%0d required 255 1", lock_loss_cnt, retry_count);
    end
    wait_ready(1'b1, n);
  endtask

  task automatic test_reset_in_run();
    int n;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_run_precond: ready got %b required 1", ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL rst_run_values: got rst=%b srn=%b rdy=%b flt=%b retry=%0d loss=%0d required 1 0 0 0 0 0",
               pll_rst, sys_rst_n, ready, fault, retry_count, lock_loss_cnt);
    end
    count_pll_rst(1'b1, n);
    checks++;
    if (n !== RP) begin
      errors++;
      $display("FAIL rst_run_pulse: got %0d required %0d", n, RP);
    end
    wait_ready(1'b1, n);
    checks++;
    if (n !== 1 + ST) begin
      errors++;
      $display("FAIL rst_run_relock: got %0d required %0d", n, 1 + ST);
    end
  endtask

  task automatic test_lock_wins_timeout();
    int n;
    do_reset();
    count_pll_rst(1'b1, n);
    repeat (TO - 3) tick();
    pll_locked = 1'b1;           // lock_s rises exactly on the final timeout cycle
    repeat (3) tick();
    checks++;
    if ({pll_rst, retry_count, fault} !== {1'b0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL lock_wins: got rst=%b retry=%0d flt=%b required 0 0 0",
               pll_rst, retry_count, fault);
    end
    wait_ready(1'b1, n);
    checks++;
    if (n !== ST) begin
      errors++;
      $display("FAIL lock_wins_run: got %0d required %0d", n, ST);
    end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_timeout_fault();
    test_clear_fault();
    test_lock_loss();
    test_stable_glitch();
    test_loss_saturation();
    test_reset_in_run();
    test_lock_wins_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: cycles pll_rst is held high per PLL reset attempt.
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 50000: cycles to wait for lock after pll_rst is released (1 ms at 50 MHz).
REQ-003 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before ready.
REQ-004 Parameter MAX_RETRIES, default 7: failed attempts tolerated before fault; range 1..15.
REQ-005 refclk  in  1  single clock; all logic is synchronous to it.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 pll_locked  in  1  PLL locked indication, asynchronous to refclk.
REQ-008 clear_fault  in  1  single-cycle pulse that restarts the sequence from FAULT.
REQ-009 pll_rst  out  1  active-high reset to the PLL.
REQ-010 sys_rst_n  out  1  active-low reset for downstream logic in the PLL output domain.
REQ-011 ready  out  1  high only in state RUN.
REQ-012 fault  out  1  high only in state FAULT.
REQ-013 retry_count  out  4  failed attempts since the last reset or clear_fault.
REQ-014 lock_loss_cnt  out  8  lock losses seen in RUN; saturates at 255.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lock_s is the synchronizer output, so latency from input to lock_s is 2 cycles.
REQ-016 FSM states SHALL be PLLRST, WAIT_LOCK, STABLE, RUN and FAULT.
REQ-017 PLLRST SHALL drive pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with the counter cleared.
REQ-018 WAIT_LOCK with lock_s=1 SHALL go to STABLE with the counter cleared.
REQ-019 WAIT_LOCK with the counter reaching LOCK_TIMEOUT_CYCLES-1 and lock_s=0 SHALL count one failed attempt.
REQ-020 STABLE with lock_s=0 before LOCK_STABLE_CYCLES is reached SHALL count one failed attempt.
REQ-021 STABLE with lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles SHALL go to RUN.
REQ-022 On a failed attempt, retry_count SHALL increment; if the new value equals MAX_RETRIES the FSM SHALL go to FAULT, otherwise to PLLRST.
REQ-023 RUN with lock_s=0 SHALL increment lock_loss_cnt (saturating) and go to PLLRST; retry_count is unchanged.
REQ-024 FAULT SHALL hold pll_rst=1 and sys_rst_n=0.
REQ-025 In FAULT, clear_fault=1 SHALL clear retry_count and go to PLLRST with the counter cleared; clear_fault SHALL be ignored in all other states.
REQ-026 If a timeout and lock_s=1 occur in the same WAIT_LOCK cycle, lock SHALL win and the FSM goes to STABLE.
REQ-027 sys_rst_n SHALL be 1 only in RUN and SHALL deassert on the same clock edge that enters RUN.
REQ-028 sys_rst_n SHALL assert in the cycle after lock_s falls.
REQ-029 All outputs SHALL be registered.
REQ-030 pll_rst SHALL be 1 in PLLRST and FAULT and 0 elsewhere.
REQ-031 One shared counter, sized for the largest of the three cycle parameters, SHALL serve all timed states and SHALL never wrap.

Reset
REQ-032 rst_n=0 sampled at a refclk edge SHALL force: state=PLLRST, counter=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, retry_count=0, lock_loss_cnt=0, synchronizer flops=0.
REQ-033 Reset asserted mid-sequence, including in RUN or FAULT, SHALL abort that sequence and restart a full PLLRST pulse after release.

Structure
REQ-034 Package pll_sup_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 The synchronizer SHALL be a separate sub-module, sync_2ff, with a 1-bit data path and a synchronous active-low reset.

Verification
Scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=3.
REQ-036 Locked rises 5 cycles after pll_rst falls and stays high -> pll_rst high exactly 4 cycles; ready=1 and sys_rst_n=1 exactly 2+8 cycles after the locked rise; retry_count=0.
REQ-037 Locked held at 0 -> three 4-cycle pll_rst pulses each followed by a 20-cycle wait; then fault=1, retry_count=3, pll_rst stays 1.
REQ-038 From fault, pulse clear_fault -> retry_count=0 and a new 4-cycle PLLRST sequence starts; a clear_fault pulse while in RUN has no effect.
REQ-039 In RUN, locked drops for 1 cycle -> sys_rst_n=0 and ready=0 three cycles after the drop; lock_loss_cnt=1; a new pll_rst pulse; relock reaches RUN.
REQ-040 Locked glitches low for 1 cycle during STABLE -> retry_count=1 and FSM returns to PLLRST; 256 forced losses in RUN -> lock_loss_cnt=255.
REQ-041 rst_n=0 for 1 cycle while in RUN -> all outputs at their REQ-032 values on the next edge; a full sequence follows.
